ssp_audio_conditioner: RTL
==========================

# ssp_audio_conditioner

Downstream audio stage for the SuperSprite PSG output. It decimates the per-clock 16-bit unsigned PSG sum to a fixed sample rate by boxcar averaging. It then removes DC with a first-order high-pass, applies a 4-bit volume with saturation, and buffers samples in a small FIFO behind a valid/ready handshake. The consumer is the HDMI/I2S audio packetiser.

## Interface
Parameters:
- DECIM_LOG2, 9: averaging window and sample period, 2^DECIM_LOG2 clocks.
- DC_SHIFT, 10: high-pass pole, alpha = 2^-DC_SHIFT.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2, ≥2.

Ports:
- clk_logic  in  1: single clock; all state updates on its rising edge.
- system_reset_n  in  1: asynchronous, active-low reset.
- enable_i  in  1: when low, window counter and accumulator are held at 0 and no ticks occur; the FIFO still drains.
- audio_i  in  16: unsigned PSG sum, sampled every enabled clock.
- volume_i  in  4: gain in 1/8 steps; 8 = unity, 0 = mute, 15 = 1.875.
- sample_o  out  16: signed two's-complement output sample (FIFO head).
- sample_valid_o  out  1: FIFO non-empty.
- sample_ready_i  in  1: consumer accept.
- clip_o  out  1: sticky; a sample saturated.
- overflow_o  out  1: sticky; a sample was dropped because the FIFO was full.
- clear_i  in  1: clears clip_o and overflow_o.

## Operation
- Window: counter cnt (DECIM_LOG2 bits) and accumulator acc (16+DECIM_LOG2 bits).
  - Each enabled clock: acc += audio_i and cnt += 1.
  - When cnt is all ones: avg_r <= (acc + audio_i) >> DECIM_LOG2, acc <= 0, cnt wraps to 0, and stage-1 valid is set.
- Stage 2 (DC block), on stage-1 valid:
  - x = {0, avg_r}, 17-bit signed.
  - dc_est = dc_acc >>> DC_SHIFT, where dc_acc is signed, 18+DC_SHIFT bits.
  - hp_r <= x − dc_est (18-bit signed).
  - dc_acc <= dc_acc + x − dc_est.
- Stage 3 (gain):
  - prod = hp_r × volume_i, with volume_i sampled this cycle and treated as unsigned.
  - scaled = prod >>> 3, arithmetic shift.
  - Saturate to [−32768, 32767] into sat_r; set clip_o on saturation.
- Stage 4 (FIFO write), on stage-3 valid:
  - Write sat_r if the FIFO is not full, or if a pop occurs in the same cycle.
  - Otherwise drop the sample and set overflow_o.
- FIFO is show-ahead: sample_o = mem[rd_ptr]; sample_valid_o = !empty. Pop happens when sample_valid_o && sample_ready_i.
- Pointers carry an extra wrap bit. Full when the pointers differ only in the MSB; empty when they are equal.
- Sticky flags: clear_i clears them. If clear_i and a set event coincide, the set wins.
- Reset values: all registers 0; sample_o=0, sample_valid_o=0, clip_o=0, overflow_o=0; FIFO empty.
- Reset asserted mid-window or mid-pipeline discards everything, including dc_acc. After release, the first tick comes after a full 2^DECIM_LOG2 enabled clocks.
- enable_i falling mid-window discards the partial window. Samples already in the pipeline or FIFO complete normally.

## Timing
- Tick edge E is the edge on which cnt == max is counted.
- Edge E loads avg_r; E+1 loads hp_r and dc_acc; E+2 loads sat_r; E+3 writes the FIFO.
- sample_valid_o is high in the cycle after E+3 if the FIFO was empty.
- Sample period is exactly 2^DECIM_LOG2 clocks while enable_i stays high. The first tick is at edge 2^DECIM_LOG2 − 1 counting from the first enabled edge.
- Pop takes effect on the edge where valid && ready. The next head is visible in the following cycle. Valid deasserts the same cycle the last entry pops.
- Push and pop in the same cycle when full: both are accepted, occupancy is unchanged, and no overflow.
- Push and pop in the same cycle when empty: not possible, because valid is low.
- Throughput: the FIFO sustains one pop per cycle; input is one push per sample period.

## Test plan
All scenarios use DECIM_LOG2=2 and DC_SHIFT=10.
- Constant input, unity gain: audio_i=1000, volume_i=8, ready=1 → first sample_o=1000 at 4 edges after the first tick. Samples then decay slowly; the 2nd sample is still 1000 because dc_est=0.
- Averaging: audio_i sequence 0,4,8,12 within one window, volume_i=8 → avg 6, first sample_o=6.
- Gain and clip:
  - audio_i=1000, volume_i=15 → first sample_o=1875, clip_o=0.
  - audio_i=65535, volume_i=15 → sample_o=32767, clip_o=1.
  - Pulse clear_i → clip_o=0.
- Mute: volume_i=0 with any input → sample_o=0, clip_o stays 0.
- Overflow: ready=0 for 5 ticks with FIFO_DEPTH=4 and input steps 100, 200, 300, 400, 500 → overflow_o=1 after the 5th tick. Raising ready then drains 100, 200, 300, 400 in order, one per cycle, and valid drops after the 4th pop.
- Reset and enable:
  - Assert system_reset_n low mid-window and mid-pipeline → all outputs 0 immediately. The next sample appears 4 edges after the tick of a full post-reset window.
  - Drop enable_i mid-window → no tick for that window.

Source files
------------

// File: rtl/ssp_audio_conditioner.sv
// Audio back end for the SuperSprite PSG: boxcar decimation, DC-blocking high-pass,
// 4-bit saturating volume and a show-ahead output FIFO with a valid/ready handshake.
module ssp_audio_conditioner #(
  parameter int unsigned DECIM_LOG2 = 9,
  parameter int unsigned DC_SHIFT   = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_logic,
  input  logic        system_reset_n,
  input  logic        enable_i,
  input  logic [15:0] audio_i,
  input  logic [3:0]  volume_i,
  output logic [15:0] sample_o,
  output logic        sample_valid_o,
  input  logic        sample_ready_i,
  output logic        clip_o,
  output logic        overflow_o,
  input  logic        clear_i
);

  localparam int unsigned AccW  = 16 + DECIM_LOG2;
  localparam int unsigned DcW   = 18 + DC_SHIFT;
  localparam int unsigned AddrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic signed [22:0] SatMax = 23'sd32767;
  localparam logic signed [22:0] SatMin = -23'sd32768;

  // ---------------------------------------------------------------------------
  // Stage 1: decimation window
  // ---------------------------------------------------------------------------
  logic [DECIM_LOG2-1:0] cnt_q;
  logic [AccW-1:0]       acc_q;
  logic [AccW-1:0]       acc_sum;
  logic [15:0]           avg_q;
  logic                  v1_q;
  logic                  tick;

  assign acc_sum = acc_q + AccW'(audio_i);
  assign tick    = enable_i && (cnt_q == '1);

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      cnt_q <= '0;
      acc_q <= '0;
      avg_q <= '0;
      v1_q  <= 1'b0;
    end else if (!enable_i) begin
      // A partial window is thrown away rather than resumed later.
      cnt_q <= '0;
      acc_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_q + DECIM_LOG2'(1);
      v1_q  <= tick;
      if (tick) begin
        acc_q <= '0;
        avg_q <= 16'(acc_sum >> DECIM_LOG2);
      end else begin
        acc_q <= acc_sum;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: first-order DC blocker, pole at 2^-DC_SHIFT
  // ---------------------------------------------------------------------------
  logic signed [DcW-1:0] dc_acc_q;
  logic signed [DcW-1:0] dc_est;
  logic signed [DcW-1:0] x_ext;
  logic signed [DcW-1:0] hp_full;
  logic signed [17:0]    hp_q;
  logic                  v2_q;

  assign x_ext   = DcW'({1'b0, avg_q});
  assign dc_est  = dc_acc_q >>> DC_SHIFT;
  assign hp_full = x_ext - dc_est;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      dc_acc_q <= '0;
      hp_q     <= '0;
      v2_q     <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        hp_q     <= hp_full[17:0];
        dc_acc_q <= dc_acc_q + hp_full;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: volume in 1/8 steps with saturation
  // ---------------------------------------------------------------------------
  logic signed [22:0] prod;
  logic signed [22:0] scaled;
  logic [15:0]        sat_val;
  logic               sat_hit;
  logic [15:0]        sat_q;
  logic               v3_q;
  logic               clip_set;

  assign prod   = hp_q * $signed({1'b0, volume_i});
  assign scaled = prod >>> 3;

  always_comb begin
    sat_val = scaled[15:0];
    sat_hit = 1'b0;
    if (scaled > SatMax) begin
      sat_val = 16'h7fff;
      sat_hit = 1'b1;
    end else if (scaled < SatMin) begin
      sat_val = 16'h8000;
      sat_hit = 1'b1;
    end
  end

  assign clip_set = v2_q && sat_hit;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      sat_q <= '0;
      v3_q  <= 1'b0;
    end else begin
      v3_q <= v2_q;
      if (v2_q) begin
        sat_q <= sat_val;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 4: show-ahead FIFO, pointers carry one extra wrap bit
  // ---------------------------------------------------------------------------
  logic [AddrW:0] wr_ptr_q;
  logic [AddrW:0] rd_ptr_q;
  logic [15:0]    mem_q [FIFO_DEPTH];
  logic           empty;
  logic           full;
  logic           pop;
  logic           push;
  logic           ovf_set;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AddrW{1'b0}}});
  assign pop   = !empty && sample_ready_i;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign push    = v3_q && (!full || pop);
  assign ovf_set = v3_q && full && !pop;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= sat_q;
        wr_ptr_q                   <= wr_ptr_q + (AddrW + 1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (AddrW + 1)'(1);
      end
    end
  end

  assign sample_o       = mem_q[rd_ptr_q[AddrW-1:0]];
  assign sample_valid_o = !empty;

  // ---------------------------------------------------------------------------
  // Sticky status; a set event on the same edge as clear_i wins
  // ---------------------------------------------------------------------------
  logic clip_q;
  logic ovf_q;

  always_ff @(posedge clk_logic or negedge system_reset_n) begin
    if (!system_reset_n) begin
      clip_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (clip_set) begin
        clip_q <= 1'b1;
      end else if (clear_i) begin
        clip_q <= 1'b0;
      end
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (clear_i) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign clip_o     = clip_q;
  assign overflow_o = ovf_q;

endmodule
